// File: rtl/varint_stream_ser.sv
// Streaming protobuf base-128 varint serializer: one integer in over valid/ready,
// one encoded byte out per cycle with last-byte flag and byte index.
module varint_stream_ser #(
  parameter int  DATA_W    = 64,
  parameter bit  ZIGZAG_EN = 1'b1,
  localparam int MAX_BYTES = (DATA_W + 6) / 7,
  localparam int IDX_W     = $clog2(MAX_BYTES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_zigzag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              out_last,
  output logic [IDX_W-1:0]  out_idx
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   sr_q, sr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                ready_q;
  logic                emit;
  logic                rest_nz;
  logic                accept;
  logic [DATA_W-1:0]   in_val;

  // Zigzag maps signed n to (n << 1) ^ (n >>> (W-1)) so small magnitudes stay short.
  function automatic logic [DATA_W-1:0] zigzag_enc(input logic signed [DATA_W-1:0] x);
    logic signed [DATA_W-1:0] t;
    t = (x <<< 1) ^ (x >>> (DATA_W - 1));
    return t;
  endfunction

  assign in_val  = (ZIGZAG_EN && in_zigzag) ? zigzag_enc(in_data) : in_data;

  assign emit    = (state_q == EMIT);
  assign rest_nz = |(sr_q >> 7);
  assign accept  = in_valid & in_ready;

  assign out_valid = emit;
  assign out_byte  = emit ? {rest_nz, sr_q[6:0]} : 8'h00;
  assign out_last  = emit & ~rest_nz;
  assign out_idx   = idx_q;

  // Accepting on the last-byte handshake lets varints run back to back without a bubble.
  assign in_ready  = ready_q & (~emit | (out_ready & ~rest_nz));

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sr_d    = in_val;
          idx_d   = '0;
          state_d = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (rest_nz) begin
            sr_d  = sr_q >> 7;
            idx_d = idx_q + IDX_W'(1);
          end else begin
            idx_d = '0;
            if (in_valid) begin
              sr_d = in_val;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      idx_q   <= idx_d;
      ready_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_varint_stream_ser.sv
// Directed bench for varint_stream_ser: hand-computed byte streams, stalls,
// back-to-back transactions and asynchronous reset during emission.
module tb_varint_stream_ser;

  localparam int DATA_W = 64;
  localparam int IDX_W  = 4;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_zigzag;
  logic              out_valid;
  logic              out_ready;
  logic [7:0]        out_byte;
  logic              out_last;
  logic [IDX_W-1:0]  out_idx;

  int n_vec;
  int n_err;

  varint_stream_ser #(.DATA_W(DATA_W), .ZIGZAG_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_zigzag (in_zigzag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_byte  (out_byte),
    .out_last  (out_last),
    .out_idx   (out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Checks one output cycle shortly after a falling edge, then moves to the next falling edge.
  task automatic expect_out(input string tag, input logic [7:0] b, input logic last,
                            input int idx, input logic rdy);
    #1;
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".byte"},  64'(out_byte),  64'(b));
    chk({tag, ".last"},  64'(out_last),  64'(last));
    chk({tag, ".idx"},   64'(out_idx),   64'(idx));
    chk({tag, ".rdy"},   64'(in_ready),  64'(rdy));
    @(negedge clk);
  endtask

  task automatic expect_idle(input string tag);
    #1;
    chk({tag, ".valid"}, 64'(out_valid), 64'd0);
    chk({tag, ".rdy"},   64'(in_ready),  64'd1);
  endtask

  // Presents one value in IDLE; it is accepted on the next rising edge.
  task automatic offer(input logic [63:0] d, input logic z);
    in_valid  = 1'b1;
    in_data   = d;
    in_zigzag = z;
    @(negedge clk);
    in_valid  = 1'b0;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_zigzag = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #2;
    chk("rst.rdy",   64'(in_ready),  64'd0);
    chk("rst.valid", 64'(out_valid), 64'd0);
    chk("rst.byte",  64'(out_byte),  64'd0);
    chk("rst.last",  64'(out_last),  64'd0);
    chk("rst.idx",   64'(out_idx),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_idle("post_rst");

    // 150 -> 0x96, 0x01
    out_ready = 1'b1;
    offer(64'd150, 1'b0);
    expect_out("v150.b0", 8'h96, 1'b0, 0, 1'b0);
    expect_out("v150.b1", 8'h01, 1'b1, 1, 1'b1);
    expect_idle("v150.end");

    // 0, 1, 300 back to back
    in_valid = 1'b1; in_data = 64'd0; in_zigzag = 1'b0;
    @(negedge clk);
    in_data = 64'd1;
    expect_out("b2b.0", 8'h00, 1'b1, 0, 1'b1);
    in_data = 64'd300;
    expect_out("b2b.1", 8'h01, 1'b1, 0, 1'b1);
    in_valid = 1'b0;
    expect_out("b2b.300a", 8'hAC, 1'b0, 0, 1'b0);
    expect_out("b2b.300b", 8'h02, 1'b1, 1, 1'b1);
    expect_idle("b2b.end");

    // All-ones unsigned: nine 0xFF then 0x01
    offer(64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    for (int i = 0; i < 9; i++) expect_out($sformatf("ones.b%0d", i), 8'hFF, 1'b0, i, 1'b0);
    expect_out("ones.b9", 8'h01, 1'b1, 9, 1'b1);
    expect_idle("ones.end");

    // Zigzag: -1 -> 1, 1 -> 2, -2 -> 3
    offer(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    expect_out("zz.m1", 8'h01, 1'b1, 0, 1'b1);
    expect_idle("zz.m1.end");
    offer(64'd1, 1'b1);
    expect_out("zz.p1", 8'h02, 1'b1, 0, 1'b1);
    expect_idle("zz.p1.end");
    offer(64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    expect_out("zz.m2", 8'h03, 1'b1, 0, 1'b1);
    expect_idle("zz.m2.end");

    // Zigzag of max positive -> 2^64-2: 0xFE, eight 0xFF, 0x01
    offer(64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    expect_out("zzmax.b0", 8'hFE, 1'b0, 0, 1'b0);
    for (int i = 1; i < 9; i++) expect_out($sformatf("zzmax.b%0d", i), 8'hFF, 1'b0, i, 1'b0);
    expect_out("zzmax.b9", 8'h01, 1'b1, 9, 1'b1);
    expect_idle("zzmax.end");

    // 16384 with out_ready pattern 1,0,0,1,1
    offer(64'd16384, 1'b0);
    out_ready = 1'b1;
    expect_out("stall.b0", 8'h80, 1'b0, 0, 1'b0);
    out_ready = 1'b0;
    expect_out("stall.h1", 8'h80, 1'b0, 1, 1'b0);
    expect_out("stall.h2", 8'h80, 1'b0, 1, 1'b0);
    out_ready = 1'b1;
    expect_out("stall.b1", 8'h80, 1'b0, 1, 1'b0);
    expect_out("stall.b2", 8'h01, 1'b1, 2, 1'b1);
    expect_idle("stall.end");

    // Asynchronous reset while byte 1 of 16384 is presented
    offer(64'd16384, 1'b0);
    expect_out("ar.b0", 8'h80, 1'b0, 0, 1'b0);
    #2;
    chk("ar.pre.idx", 64'(out_idx), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("ar.valid", 64'(out_valid), 64'd0);
    chk("ar.idx",   64'(out_idx),   64'd0);
    chk("ar.rdy",   64'(in_ready),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    expect_idle("ar.post");
    chk("ar.post.idx", 64'(out_idx), 64'd0);
    offer(64'd5, 1'b0);
    expect_out("ar.v5", 8'h05, 1'b1, 0, 1'b1);
    expect_idle("ar.end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
